// File: rtl/musa_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | musa_ctrl_pkg: shared types and encodings for the MUSA control   |
// | unit (states, instruction classes, opcodes, ALU operations).     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package musa_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP     = 4'd0,
    CLS_ALU     = 4'd1,
    CLS_LW      = 4'd2,
    CLS_SW      = 4'd3,
    CLS_BEQ     = 4'd4,
    CLS_J       = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_RET     = 4'd7,
    CLS_HALT    = 4'd8,
    CLS_ILLEGAL = 4'd9,
    CLS_MEMERR  = 4'd10
  } class_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_MUL = 4'd4,
    ALU_DIV = 4'd5
  } alu_op_e;

  // Everything later states need about the instruction, captured in DECODE.
  typedef struct packed {
    class_e  cls;
    alu_op_e op;
    logic    imm;
  } dec_t;

  localparam dec_t c_dec_nop = '{cls: CLS_NOP, op: ALU_ADD, imm: 1'b0};

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_jal   = 6'b000011;
  localparam logic [5:0] c_op_ret   = 6'b011111;
  localparam logic [5:0] c_op_halt  = 6'b111111;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_mul = 6'b011000;
  localparam logic [5:0] c_fn_div = 6'b011010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;

endpackage
`default_nettype wire

// File: rtl/musa_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | musa_decode: combinational opcode/funct to instruction class.    |
// | Build option: CTRL_STACK_EN enables jal/ret decode.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module musa_decode
  import musa_ctrl_pkg::*;
#(
  parameter int FUNC_W = 6
) (
  input  logic [5:0]        opcode,
  input  logic [FUNC_W-1:0] funct,
  output dec_t              dec,
  output logic              illegal
);

  always_comb begin
    dec = '{cls: CLS_ILLEGAL, op: ALU_ADD, imm: 1'b0};
    case (opcode)
      c_op_rtype: begin
        dec.cls = CLS_ALU;
        case (funct)
          FUNC_W'(c_fn_add): dec.op = ALU_ADD;
          FUNC_W'(c_fn_sub): dec.op = ALU_SUB;
          FUNC_W'(c_fn_mul): dec.op = ALU_MUL;
          FUNC_W'(c_fn_div): dec.op = ALU_DIV;
          FUNC_W'(c_fn_and): dec.op = ALU_AND;
          FUNC_W'(c_fn_or):  dec.op = ALU_OR;
          default:           dec.cls = CLS_ILLEGAL;
        endcase
      end
      c_op_addi: dec = '{cls: CLS_ALU, op: ALU_ADD, imm: 1'b1};
      c_op_andi: dec = '{cls: CLS_ALU, op: ALU_AND, imm: 1'b1};
      c_op_ori:  dec = '{cls: CLS_ALU, op: ALU_OR,  imm: 1'b1};
      c_op_lw:   dec = '{cls: CLS_LW,  op: ALU_ADD, imm: 1'b1};
      c_op_sw:   dec = '{cls: CLS_SW,  op: ALU_ADD, imm: 1'b1};
      c_op_beq:  dec = '{cls: CLS_BEQ, op: ALU_SUB, imm: 1'b0};
      c_op_j:    dec.cls = CLS_J;
`ifdef CTRL_STACK_EN
      c_op_jal:  dec.cls = CLS_JAL;
      c_op_ret:  dec.cls = CLS_RET;
`endif
      c_op_halt: dec.cls = CLS_HALT;
      default:   dec.cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (dec.cls == CLS_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with      |
// | memory timeout. Build option: CTRL_STACK_EN (jal/ret stack).     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module multicycle_control
  import musa_ctrl_pkg::*;
#(
  parameter int FUNC_W      = 6,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [FUNC_W-1:0]   funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_read,
  output logic                reg_write,
  output logic                wb_sel,
  output logic                alu_src_imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                push,
  output logic                pop,
  output logic                halted,
  output logic                illegal,
  output logic                mem_err
);

  state_e     r_state, w_next;
  dec_t       r_dec, w_dec, w_dec_next;
  logic       w_dec_illegal;
  logic [7:0] r_wait, w_wait_next;
  logic       w_mem_phase, w_timeout;
  alu_op_e    w_alu;

  musa_decode #(.FUNC_W(FUNC_W)) u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .dec     (w_dec),
    .illegal (w_dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_dec   <= c_dec_nop;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_dec   <= w_dec_next;
      r_wait  <= w_wait_next;
    end
  end

  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
  // A ready on the timeout cycle still completes the access.
  assign w_timeout   = w_mem_phase && !mem_ready && (r_wait == 8'(MEM_TIMEOUT));

  always_comb begin
    w_next     = r_state;
    w_dec_next = r_dec;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        w_dec_next = w_dec;
        w_next = (w_dec_illegal || (w_dec.cls == CLS_HALT)) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (r_dec.cls)
          CLS_ALU:        w_next = S_WB;
          CLS_LW, CLS_SW: w_next = S_MEM;
          default:        w_next = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ready) w_next = (r_dec.cls == CLS_LW) ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
    if (w_timeout) begin
      w_next         = S_HALT;
      w_dec_next.cls = CLS_MEMERR;
    end
  end

  // Counter restarts whenever FETCH or MEM is (re)entered.
  always_comb begin
    w_wait_next = '0;
    if (w_mem_phase && (w_next == r_state) && !mem_ready)
      w_wait_next = r_wait + 8'd1;
  end

  always_comb begin
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    reg_read    = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    alu_src_imm = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    mem_err     = 1'b0;
    w_alu       = ALU_ADD;
    // Outputs are forced low for as long as reset is held.
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_load  = mem_ready;
        end
        S_DECODE: reg_read = 1'b1;
        S_EXEC: begin
          w_alu       = r_dec.op;
          alu_src_imm = r_dec.imm;
          case (r_dec.cls)
            CLS_BEQ: begin
              pc_write = 1'b1;
              pc_src   = zero ? 2'b01 : 2'b00;
            end
            CLS_J: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
            end
`ifdef CTRL_STACK_EN
            CLS_JAL: begin
              push     = 1'b1;
              pc_write = 1'b1;
              pc_src   = 2'b10;
            end
            CLS_RET: begin
              pop      = 1'b1;
              pc_write = 1'b1;
              pc_src   = 2'b11;
            end
`endif
            default: ;
          endcase
        end
        S_MEM: begin
          if (r_dec.cls == CLS_SW) begin
            mem_write = 1'b1;
            pc_write  = mem_ready;
          end else begin
            mem_read  = 1'b1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = (r_dec.cls == CLS_LW);
          pc_write  = 1'b1;
        end
        S_HALT: begin
          halted  = 1'b1;
          illegal = (r_dec.cls == CLS_ILLEGAL);
          mem_err = (r_dec.cls == CLS_MEMERR);
        end
        default: ;
      endcase
    end
  end

  assign alu_op = ALU_OP_W'(w_alu);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_multicycle_control: random instruction stream checked against |
// | a per-instruction cycle-schedule model of the control unit.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_multicycle_control;

  localparam int T = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_load, pc_write, reg_read, reg_write, wb_sel, alu_src_imm;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic       mem_read, mem_write, push, pop, halted, illegal, mem_err;

  multicycle_control #(.FUNC_W(6), .ALU_OP_W(4), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_write(pc_write),
    .pc_src(pc_src), .reg_read(reg_read), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
    .halted(halted), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_read;
    logic       reg_write;
    logic       wb_sel;
    logic       alu_src_imm;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       push;
    logic       pop;
    logic       halted;
    logic       illegal;
    logic       mem_err;
  } outs_t;

  logic [18:0] obs_v;
  assign obs_v = {ir_load, pc_write, pc_src, reg_read, reg_write, wb_sel,
                  alu_src_imm, alu_op, mem_read, mem_write, push, pop,
                  halted, illegal, mem_err};

  typedef enum {K_ALU, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_RET, K_HALT, K_ILL} kind_e;
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    kind_e      kind;
    logic [3:0] alu;
    logic       imm;
  } ent_t;

  int n_chk = 0;
  int n_err = 0;
  logic [5:0] cur_op, cur_fn;
  logic       cur_zero;

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b want %b", tag, $time, got, exp);
    end
  endtask

  // Fields: ir pcw pcsrc rr rw wb imm aluop mr mw push pop h il me
  function automatic ent_t pick(int i);
    ent_t e;
    e.fn = 6'($urandom); e.alu = 4'd0; e.imm = 1'b0; e.kind = K_ILL; e.op = 6'b110011;
    case (i)
      0:  begin e.op = 6'b000000; e.fn = 6'b100000; e.kind = K_ALU; e.alu = 4'd0; end
      1:  begin e.op = 6'b000000; e.fn = 6'b100010; e.kind = K_ALU; e.alu = 4'd1; end
      2:  begin e.op = 6'b000000; e.fn = 6'b011000; e.kind = K_ALU; e.alu = 4'd4; end
      3:  begin e.op = 6'b000000; e.fn = 6'b011010; e.kind = K_ALU; e.alu = 4'd5; end
      4:  begin e.op = 6'b000000; e.fn = 6'b100100; e.kind = K_ALU; e.alu = 4'd2; end
      5:  begin e.op = 6'b000000; e.fn = 6'b100101; e.kind = K_ALU; e.alu = 4'd3; end
      6:  begin e.op = 6'b000000; e.fn = 6'b100110; e.kind = K_ILL; end
      7:  begin e.op = 6'b001000; e.kind = K_ALU; e.alu = 4'd0; e.imm = 1'b1; end
      8:  begin e.op = 6'b001100; e.kind = K_ALU; e.alu = 4'd2; e.imm = 1'b1; end
      9:  begin e.op = 6'b001101; e.kind = K_ALU; e.alu = 4'd3; e.imm = 1'b1; end
      10: begin e.op = 6'b100011; e.kind = K_LW; e.imm = 1'b1; end
      11: begin e.op = 6'b101011; e.kind = K_SW; e.imm = 1'b1; end
      12: begin e.op = 6'b000100; e.kind = K_BEQ; e.alu = 4'd1; end
      13: begin e.op = 6'b000010; e.kind = K_J; end
`ifdef CTRL_STACK_EN
      14: begin e.op = 6'b000011; e.kind = K_JAL; end
      15: begin e.op = 6'b011111; e.kind = K_RET; end
`else
      14: begin e.op = 6'b000011; e.kind = K_ILL; end
      15: begin e.op = 6'b011111; e.kind = K_ILL; end
`endif
      16: begin e.op = 6'b111111; e.kind = K_HALT; end
      17: begin e.op = 6'b110011; e.kind = K_ILL; end
      default: begin e.op = 6'b000001; e.kind = K_ILL; end
    endcase
    return e;
  endfunction

  // Number of wait cycles before ready; above T means the access times out.
  function automatic int pick_wait();
    int r = int'($urandom_range(0, 99));
    if (r < 60) return 0;
    if (r < 84) return int'($urandom_range(1, 4));
    if (r < 90) return T;
    if (r < 94) return T - 1;
    return T + 1 + int'($urandom_range(0, 2));
  endfunction

  task automatic step(input string tag, input logic rdy, input bit fetch, input outs_t e);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = rdy;
    zero = cur_zero;
    if (fetch) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
    end else begin
      opcode = cur_op;
      funct  = cur_fn;
    end
    @(negedge clk);
    check(tag, obs_v, e);
  endtask

  task automatic do_reset();
    outs_t z = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ready = 1'($urandom);
    #1 check("reset_async", obs_v, z);
    @(negedge clk);
    check("reset", obs_v, z);
    @(posedge clk); #1;
    mem_ready = 1'($urandom);
    @(negedge clk);
    check("reset_hold", obs_v, z);
  endtask

  task automatic halt_tail(input logic il, input logic me);
    outs_t e = '0;
    e.halted = 1'b1; e.illegal = il; e.mem_err = me;
    repeat (2) step("halt", 1'($urandom), 1'b0, e);
    do_reset();
  endtask

  // Runs a memory phase of n wait cycles; returns 1 if it timed out into HALT.
  task automatic mem_phase(input string tag, input int n, input bit fetch,
                           input outs_t wait_e, input outs_t done_e, output bit to);
    to = 1'b0;
    if (n > T) begin
      for (int i = 0; i <= T; i++) step({tag, "_wait"}, 1'b0, fetch, wait_e);
      halt_tail(1'b0, 1'b1);
      to = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) step({tag, "_wait"}, 1'b0, fetch, wait_e);
      step(tag, 1'b1, fetch, done_e);
    end
  endtask

  task automatic run_instr();
    ent_t  en = pick(int'($urandom_range(0, 18)));
    outs_t e, d;
    bit    to;
    cur_op = en.op; cur_fn = en.fn; cur_zero = 1'($urandom);

    e = '0; e.mem_read = 1'b1;
    d = e;  d.ir_load = 1'b1;
    mem_phase("fetch", pick_wait(), 1'b1, e, d, to);
    if (to) return;
    if ($urandom_range(0, 99) < 4) begin
      do_reset();
      return;
    end

    e = '0; e.reg_read = 1'b1;
    step("decode", 1'($urandom), 1'b0, e);

    if (en.kind == K_HALT) begin halt_tail(1'b0, 1'b0); return; end
    if (en.kind == K_ILL)  begin halt_tail(1'b1, 1'b0); return; end

    cur_zero = 1'($urandom);
    e = '0; e.alu_op = en.alu; e.alu_src_imm = en.imm;
    case (en.kind)
      K_BEQ: begin e.pc_write = 1'b1; e.pc_src = cur_zero ? 2'b01 : 2'b00; end
      K_J:   begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
      K_JAL: begin e.pc_write = 1'b1; e.pc_src = 2'b10; e.push = 1'b1; end
      K_RET: begin e.pc_write = 1'b1; e.pc_src = 2'b11; e.pop = 1'b1; end
      default: ;
    endcase
    step("exec", 1'($urandom), 1'b0, e);

    if (en.kind == K_LW || en.kind == K_SW) begin
      e = '0;
      if (en.kind == K_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
      d = e;
      if (en.kind == K_SW) d.pc_write = 1'b1;
      mem_phase("mem", pick_wait(), 1'b0, e, d, to);
      if (to) return;
    end

    if (en.kind == K_ALU || en.kind == K_LW) begin
      e = '0; e.reg_write = 1'b1; e.pc_write = 1'b1; e.wb_sel = (en.kind == K_LW);
      step("wb", 1'($urandom), 1'b0, e);
    end
  endtask

  initial begin
    outs_t z = '0;
    cur_op = '0; cur_fn = '0; cur_zero = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_init", obs_v, z);
    for (int n = 0; n < 300; n++) run_instr();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
